// File: rtl/cpu_mem_responder_if.sv
// Bus bundle for cpu_mem_responder: fetch, program-load, data-write and debug-read signals.
// slave is the responder side, master is the CPU/host side.
interface cpu_mem_responder_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_insn;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data;
    logic        dmem_wen;
    logic        prog_wen;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        dbg_ren;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_rdata;
    logic [2:0]  wb_count;
    logic        wb_full;
    logic        ovf_err;
    logic [15:0] wr_count;
    logic        align_err;

    modport slave (
        input  imem_addr, dmem_addr, dmem_data, dmem_wen,
        input  prog_wen, prog_addr, prog_data, dbg_ren, dbg_addr,
        output imem_insn, dbg_rdata, wb_count, wb_full, ovf_err, wr_count, align_err
    );

    modport master (
        output imem_addr, dmem_addr, dmem_data, dmem_wen,
        output prog_wen, prog_addr, prog_data, dbg_ren, dbg_addr,
        input  imem_insn, dbg_rdata, wb_count, wb_full, ovf_err, wr_count, align_err
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Instruction/data memory responder: 256-word IMEM and DMEM, DMEM writes via a 4-entry write buffer.
// Optional macro MEM_RESP_ALIGN_CHECK_EN drops misaligned writes, NOPs misaligned fetches, sets align_err.
module cpu_mem_responder (
    input logic                clk,
    input logic                rst_n,
    cpu_mem_responder_if.slave bus
);
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    logic [31:0] r_imem [0:255];
    logic [31:0] r_dmem [0:255];
    logic [7:0]  r_wb_idx  [0:3];
    logic [31:0] r_wb_data [0:3];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_wb_count;
    logic        r_wb_full;
    logic        r_ovf_err;
    logic [15:0] r_wr_count;
    logic [31:0] r_imem_insn;
    logic [31:0] r_dbg_rdata;

    logic [7:0]  w_fetch_idx;
    logic [7:0]  w_prog_idx;
    logic [7:0]  w_dmem_idx;
    logic [7:0]  w_dbg_idx;
    logic        w_fetch_ok;
    logic        w_prog_ok;
    logic        w_dmem_ok;
    logic        w_drain;
    logic        w_push;
    logic        w_ovf;
    logic [2:0]  w_count_nxt;
    logic [1:0]  w_slot;
    logic        w_match;
    logic        w_fwd_hit;
    logic [31:0] w_fwd_data;
    logic [31:0] w_dbg_nxt;
    logic [31:0] w_insn_nxt;
    logic        w_unused;

    assign w_fetch_idx = bus.imem_addr[9:2];
    assign w_prog_idx  = bus.prog_addr[9:2];
    assign w_dmem_idx  = bus.dmem_addr[9:2];
    assign w_dbg_idx   = bus.dbg_addr[9:2];

`ifdef MEM_RESP_ALIGN_CHECK_EN
    logic r_align_err;
    logic w_align_bad;

    assign w_fetch_ok = (bus.imem_addr[1:0] == 2'b00);
    assign w_prog_ok  = (bus.prog_addr[1:0] == 2'b00);
    assign w_dmem_ok  = (bus.dmem_addr[1:0] == 2'b00);
    assign w_align_bad = !w_fetch_ok || (bus.prog_wen && !w_prog_ok) || (bus.dmem_wen && !w_dmem_ok);
    assign w_unused = ^{bus.imem_addr[31:10], bus.prog_addr[31:10], bus.dmem_addr[31:10],
                        bus.dbg_addr[31:10], bus.dbg_addr[1:0]};

    // Sticky misalignment flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_align_err <= 1'b0;
        end else if (w_align_bad) begin
            r_align_err <= 1'b1;
        end else begin
            r_align_err <= r_align_err;
        end
    end

    assign bus.align_err = r_align_err;
`else
    assign w_fetch_ok = 1'b1;
    assign w_prog_ok  = 1'b1;
    assign w_dmem_ok  = 1'b1;
    assign w_unused = ^{bus.imem_addr[31:10], bus.imem_addr[1:0], bus.prog_addr[31:10], bus.prog_addr[1:0],
                        bus.dmem_addr[31:10], bus.dmem_addr[1:0], bus.dbg_addr[31:10], bus.dbg_addr[1:0]};
    assign bus.align_err = 1'b0;
`endif

    // Write-buffer push/drain decisions and next occupancy
    always_comb begin
        w_drain     = 1'b0;
        w_push      = 1'b0;
        w_ovf       = 1'b0;
        w_count_nxt = r_wb_count;
        w_drain = (r_wb_count != 3'd0) && !bus.dbg_ren;
        // A full buffer still accepts when the head leaves on the same edge
        w_push  = bus.dmem_wen && w_dmem_ok && ((r_wb_count != 3'd4) || w_drain);
        w_ovf   = bus.dmem_wen && w_dmem_ok && (r_wb_count == 3'd4) && !w_drain;
        case ({w_push, w_drain})
            2'b10:   w_count_nxt = r_wb_count + 3'd1;
            2'b01:   w_count_nxt = r_wb_count - 3'd1;
            default: w_count_nxt = r_wb_count;
        endcase
    end

    // Debug read: youngest buffered entry wins, scanned oldest to youngest
    always_comb begin
        w_slot     = 2'd0;
        w_match    = 1'b0;
        w_fwd_hit  = 1'b0;
        w_fwd_data = 32'd0;
        for (int k = 0; k < 4; k++) begin
            w_slot     = r_rd_ptr + 2'(k);
            w_match    = (3'(k) < r_wb_count) && (r_wb_idx[w_slot] == w_dbg_idx);
            w_fwd_hit  = w_fwd_hit | w_match;
            w_fwd_data = w_match ? r_wb_data[w_slot] : w_fwd_data;
        end
        w_dbg_nxt  = w_fwd_hit ? w_fwd_data : r_dmem[w_dbg_idx];
        w_insn_nxt = w_fetch_ok ? r_imem[w_fetch_idx] : NOP_INSN;
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imem_insn <= NOP_INSN;
            r_dbg_rdata <= 32'd0;
            r_wr_ptr    <= 2'd0;
            r_rd_ptr    <= 2'd0;
            r_wb_count  <= 3'd0;
            r_wb_full   <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_wr_count  <= 16'd0;
        end else begin
            r_imem_insn <= w_insn_nxt;
            r_wb_count  <= w_count_nxt;
            r_wb_full   <= (w_count_nxt == 3'd4);
            if (bus.dbg_ren) begin
                r_dbg_rdata <= w_dbg_nxt;
            end
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 2'd1;
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_drain) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            if (w_ovf) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    // Storage arrays and buffer payload survive reset; only pointers are cleared
    always_ff @(posedge clk) begin
        if (bus.prog_wen && w_prog_ok) begin
            r_imem[w_prog_idx] <= bus.prog_data;
        end
        if (w_drain) begin
            r_dmem[r_wb_idx[r_rd_ptr]] <= r_wb_data[r_rd_ptr];
        end
        if (w_push) begin
            r_wb_idx[r_wr_ptr]  <= w_dmem_idx;
            r_wb_data[r_wr_ptr] <= bus.dmem_data;
        end
    end

    assign bus.imem_insn = r_imem_insn;
    assign bus.dbg_rdata = r_dbg_rdata;
    assign bus.wb_count  = r_wb_count;
    assign bus.wb_full   = r_wb_full;
    assign bus.ovf_err   = r_ovf_err;
    assign bus.wr_count  = r_wr_count;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: queue-based memory model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cpu_mem_responder;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef MEM_RESP_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    cpu_mem_responder_if bus();

    cpu_mem_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] data;
    } wb_t;

    logic [31:0] m_imem   [256];
    bit          m_imem_v [256];
    logic [31:0] m_dmem   [256];
    bit          m_dmem_v [256];
    wb_t         m_q [$];
    logic [31:0] m_insn = 32'd0;
    logic [31:0] m_dbg  = 32'd0;
    bit          m_insn_k = 1'b0;
    bit          m_dbg_k  = 1'b0;
    bit          m_ovf    = 1'b0;
    bit          m_align  = 1'b0;
    logic [15:0] m_wr     = 16'd0;
    logic [7:0]  t_i;
    bit          t_hit;
    bit          t_drain;
    int          t_n;
    wb_t         t_e;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;
    int fill_exp [5] = '{1, 2, 3, 4, 4};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: memories as arrays, write buffer as a queue
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_insn = NOP; m_insn_k = 1'b1;
            m_dbg = 32'd0; m_dbg_k = 1'b1;
            m_ovf = 1'b0; m_align = 1'b0; m_wr = 16'd0;
        end else begin
            if (ALIGN_EN && bus.imem_addr[1:0] != 2'b00) begin
                m_insn = NOP; m_insn_k = 1'b1; m_align = 1'b1;
            end else begin
                t_i = bus.imem_addr[9:2];
                m_insn = m_imem[t_i]; m_insn_k = m_imem_v[t_i];
            end
            if (bus.dbg_ren) begin
                t_i = bus.dbg_addr[9:2];
                t_hit = 1'b0;
                for (int k = m_q.size() - 1; k >= 0; k--) begin
                    if (!t_hit && m_q[k].idx == t_i) begin
                        m_dbg = m_q[k].data; m_dbg_k = 1'b1; t_hit = 1'b1;
                    end
                end
                if (!t_hit) begin
                    m_dbg = m_dmem[t_i]; m_dbg_k = m_dmem_v[t_i];
                end
            end
            t_n = m_q.size();
            t_drain = (t_n > 0) && !bus.dbg_ren;
            if (t_drain) begin
                t_e = m_q.pop_front();
                m_dmem[t_e.idx] = t_e.data; m_dmem_v[t_e.idx] = 1'b1;
            end
            if (bus.dmem_wen) begin
                if (ALIGN_EN && bus.dmem_addr[1:0] != 2'b00) m_align = 1'b1;
                else if (t_n < 4 || t_drain) begin
                    t_e.idx = bus.dmem_addr[9:2]; t_e.data = bus.dmem_data;
                    m_q.push_back(t_e);
                    m_wr = m_wr + 16'd1;
                end else m_ovf = 1'b1;
            end
            if (bus.prog_wen) begin
                if (ALIGN_EN && bus.prog_addr[1:0] != 2'b00) m_align = 1'b1;
                else begin
                    m_imem[bus.prog_addr[9:2]] = bus.prog_data;
                    m_imem_v[bus.prog_addr[9:2]] = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_insn_k) check("imem_insn", bus.imem_insn, m_insn);
            if (m_dbg_k) check("dbg_rdata", bus.dbg_rdata, m_dbg);
            check("wb_count", 32'(bus.wb_count), 32'(m_q.size()));
            check("wb_full", 32'(bus.wb_full), 32'(m_q.size() == 4));
            check("ovf_err", 32'(bus.ovf_err), 32'(m_ovf));
            check("wr_count", 32'(bus.wr_count), 32'(m_wr));
            check("align_err", 32'(bus.align_err), 32'(m_align));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.prog_wen = 1'b0; bus.dmem_wen = 1'b0; bus.dbg_ren = 1'b0;
    endtask

    task automatic reset_literals();
        check("rst_wb_count", 32'(bus.wb_count), 32'd0);
        check("rst_wb_full", 32'(bus.wb_full), 32'd0);
        check("rst_ovf", 32'(bus.ovf_err), 32'd0);
        check("rst_wr_count", 32'(bus.wr_count), 32'd0);
        check("rst_insn", bus.imem_insn, 32'h0000_0013);
        check("rst_dbg", bus.dbg_rdata, 32'd0);
        check("rst_align", 32'(bus.align_err), 32'd0);
    endtask

    task automatic do_reset();
        idle();
        #2 rst_n = 1'b0;
        #1 reset_literals();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.imem_addr = 32'd0; bus.dmem_addr = 32'd0; bus.dmem_data = 32'd0;
        bus.prog_addr = 32'd0; bus.prog_data = 32'd0; bus.dbg_addr = 32'd0;
        idle();
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        reset_literals();
        tick();
        rst_n = 1'b1;

        // Load IMEM, fetching the word written the cycle before
        for (int i = 0; i < 256; i++) begin
            bus.prog_wen  = 1'b1;
            bus.prog_addr = 32'(i) * 32'd4;
            bus.prog_data = 32'hC0DE_0000 | 32'(i);
            bus.imem_addr = (i == 0) ? 32'd0 : 32'(i - 1) * 32'd4;
            tick();
        end
        bus.prog_wen = 1'b0;
        // Fill DMEM through the buffer, upper address bits set to show they are ignored
        for (int i = 0; i < 256; i++) begin
            bus.dmem_wen  = 1'b1;
            bus.dmem_addr = (32'(i) * 32'd4) | 32'h0000_FC00;
            bus.dmem_data = 32'hD000_0000 | 32'(i);
            bus.imem_addr = 32'(i) * 32'd4;
            tick();
        end
        bus.dmem_wen = 1'b0;
        tick();
        check("init_wr_count", 32'(bus.wr_count), 32'd256);
        check("init_drained", 32'(bus.wb_count), 32'd0);

        // Program load, read-before-write, wrap
        bus.prog_wen = 1'b1; bus.prog_addr = 32'h8; bus.prog_data = 32'h0050_0093;
        bus.imem_addr = 32'h8;
        tick();
        check("rbw_old", bus.imem_insn, 32'hC0DE_0002);
        bus.prog_wen = 1'b0;
        tick();
        check("fetch_new", bus.imem_insn, 32'h0050_0093);
        bus.imem_addr = 32'h408;
        tick();
        check("fetch_wrap", bus.imem_insn, 32'h0050_0093);

        // Overflow with debug read held
        do_reset();
        bus.dbg_ren = 1'b1; bus.dbg_addr = 32'h3FC;
        for (int k = 0; k < 5; k++) begin
            bus.dmem_wen = 1'b1; bus.dmem_addr = 32'h20 + 32'(k) * 32'd4; bus.dmem_data = 32'(k);
            tick();
            check("fill_count", 32'(bus.wb_count), 32'(fill_exp[k]));
        end
        bus.dmem_wen = 1'b0;
        check("ovf_set", 32'(bus.ovf_err), 32'd1);
        check("ovf_wr_count", 32'(bus.wr_count), 32'd4);
        check("ovf_full", 32'(bus.wb_full), 32'd1);
        check("dbg_dmem_ff", bus.dbg_rdata, 32'hD000_00FF);
        bus.dbg_addr = 32'h24;
        tick();
        check("dbg_fwd_1", bus.dbg_rdata, 32'd1);
        bus.dbg_ren = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("drained_empty", 32'(bus.wb_count), 32'd0);
        check("dbg_hold", bus.dbg_rdata, 32'd1);
        bus.dbg_ren = 1'b1; bus.dbg_addr = 32'h2C;
        tick();
        check("dbg_after_drain", bus.dbg_rdata, 32'd3);
        check("ovf_sticky", 32'(bus.ovf_err), 32'd1);

        // Youngest-match forwarding
        do_reset();
        bus.dbg_ren = 1'b1; bus.dbg_addr = 32'h3FC;
        bus.dmem_wen = 1'b1; bus.dmem_addr = 32'h10; bus.dmem_data = 32'h0000_AAAA;
        tick();
        bus.dmem_data = 32'h0000_BBBB;
        tick();
        bus.dmem_wen = 1'b0; bus.dbg_addr = 32'h10;
        tick();
        check("fwd_youngest", bus.dbg_rdata, 32'h0000_BBBB);
        bus.dbg_addr = 32'h14;
        bus.dmem_wen = 1'b1; bus.dmem_addr = 32'h14; bus.dmem_data = 32'h0000_1234;
        tick();
        check("no_same_cycle_fwd", bus.dbg_rdata, 32'hD000_0005);
        bus.dmem_wen = 1'b0; bus.dbg_ren = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        bus.dbg_ren = 1'b1; bus.dbg_addr = 32'h10;
        tick();
        check("dmem_bbbb", bus.dbg_rdata, 32'h0000_BBBB);
        bus.dbg_addr = 32'h14;
        tick();
        check("dmem_1234", bus.dbg_rdata, 32'h0000_1234);

        // Full buffer accepts when draining
        do_reset();
        bus.dbg_ren = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.dmem_wen = 1'b1; bus.dmem_addr = 32'h30 + 32'(k) * 32'd4; bus.dmem_data = 32'h3000 + 32'(k);
            tick();
        end
        bus.dbg_ren = 1'b0; bus.dmem_addr = 32'h40; bus.dmem_data = 32'h0000_4444;
        tick();
        check("full_drain_count", 32'(bus.wb_count), 32'd4);
        check("full_drain_ovf", 32'(bus.ovf_err), 32'd0);
        check("full_drain_wr", 32'(bus.wr_count), 32'd5);
        bus.dmem_wen = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        bus.dbg_ren = 1'b1; bus.dbg_addr = 32'h40;
        tick();
        check("full_drain_data", bus.dbg_rdata, 32'h0000_4444);

        // Reset while draining
        do_reset();
        bus.dbg_ren = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.dmem_wen = 1'b1; bus.dmem_addr = 32'h50 + 32'(k) * 32'd4; bus.dmem_data = 32'hE0 + 32'(k);
            tick();
        end
        bus.dmem_wen = 1'b0; bus.dbg_ren = 1'b0;
        tick();
        check("mid_drain_count", 32'(bus.wb_count), 32'd3);
        #2 rst_n = 1'b0;
        #1 reset_literals();
        tick();
        rst_n = 1'b1;
        bus.dbg_ren = 1'b1; bus.dbg_addr = 32'h50;
        tick();
        check("retained_drained", bus.dbg_rdata, 32'h0000_00E0);
        bus.dbg_addr = 32'h54;
        tick();
        check("discarded_entry", bus.dbg_rdata, 32'hD000_0015);

        // Misaligned write and fetch
        bus.dbg_ren = 1'b0;
        bus.dmem_wen = 1'b1; bus.dmem_addr = 32'h12; bus.dmem_data = 32'h0000_5555;
        bus.imem_addr = 32'h9;
        tick();
        bus.dmem_wen = 1'b0;
        tick();
        bus.dbg_ren = 1'b1; bus.dbg_addr = 32'h10;
        tick();
`ifdef MEM_RESP_ALIGN_CHECK_EN
        check("misalign_err", 32'(bus.align_err), 32'd1);
        check("misalign_wr", 32'(bus.wr_count), 32'd0);
        check("misalign_data", bus.dbg_rdata, 32'h0000_BBBB);
        check("misalign_fetch", bus.imem_insn, 32'h0000_0013);
`else
        check("misalign_err", 32'(bus.align_err), 32'd0);
        check("misalign_wr", 32'(bus.wr_count), 32'd1);
        check("misalign_data", bus.dbg_rdata, 32'h0000_5555);
        check("misalign_fetch", bus.imem_insn, 32'h0050_0093);
`endif
        idle();
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
